// File: rtl/bcd_serial_adder_ctrl_if.sv
// Requester-side bundle for the digit-serial BCD adder: operands, handshake and result.
interface bcd_serial_adder_ctrl_if #(
  parameter int unsigned NDIG = 6
);
  logic              start;
  logic [4*NDIG-1:0] op_a;
  logic [4*NDIG-1:0] op_b;
  logic              cin;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] result;
  logic              cout;
  logic              err;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, result, cout, err
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, result, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one shared digit adder, one digit per clock, LSB first.
module bcd_serial_adder_ctrl #(
  parameter int unsigned NDIG = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_serial_adder_ctrl_if.slave  bus
);
  localparam int unsigned W    = 4 * NDIG;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q, b_q;
  logic [W-1:0]    result_q;
  logic            cout_q, err_q, busy_q, done_q;

  logic [3:0]      a_d, b_d, sum_d;
  logic [4:0]      t;
  logic            c_out;
  logic            last_c;
  logic            bad_c;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.err    = err_q;

  // Select the current digit pair and run the shared BCD digit adder on it.
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx_q == IDXW'(i)) begin
        a_d = a_q[i*4 +: 4];
        b_d = b_q[i*4 +: 4];
      end
    end
    t = 5'(a_d) + 5'(b_d) + 5'(carry_q);
    if (t > 5'd9) begin
      sum_d = 4'(t + 5'd6);
      c_out = 1'b1;
    end else begin
      sum_d = t[3:0];
      c_out = 1'b0;
    end
    last_c = (idx_q == IDXW'(NDIG - 1));
  end

  // Flag any non-BCD digit on the incoming operands.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if ((bus.op_a[i*4 +: 4] > 4'd9) || (bus.op_b[i*4 +: 4] > 4'd9)) begin
        bad_c = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Operand latch on accept, then per-digit result write and carry ripple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.op_a;
            b_q      <= bus.op_b;
            carry_q  <= bus.cin;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= bad_c;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NDIG); i++) begin
            if (idx_q == IDXW'(i)) result_q[i*4 +: 4] <= sum_d;
          end
          carry_q <= c_out;
          if (last_c) cout_q <= c_out;
          else        idx_q  <= idx_q + IDXW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the digit-serial BCD adder with hand-computed sums.
module tb_bcd_serial_adder_ctrl;
  localparam int unsigned NDIG = 6;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   done_at;
  int   busy_cnt;
  int   done_cnt;
  int   first_done;
  int   second_done;

  bcd_serial_adder_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done; all sampling on negedges.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic c);
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    done_at   = 0;
    busy_cnt  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.op_a  = 24'h555555;
        bus.op_b  = 24'h444444;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = i;
        break;
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.cin    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_cout",   32'(bus.cout),   32'd0);
    check("reset_err",    32'(bus.err),    32'd0);
    rst_n = 1'b1;

    // Basic add with a two-digit carry chain.
    run_op(24'h095959, 24'h000001, 1'b0);
    check("t1_done_at", 32'(done_at),    32'd7);
    check("t1_busy",    32'(busy_cnt),   32'd6);
    check("t1_result",  32'(bus.result), 32'h095960);
    check("t1_cout",    32'(bus.cout),   32'd0);
    check("t1_err",     32'(bus.err),    32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(bus.done), 32'd0);
    check("t1_result_held",    32'(bus.result), 32'h095960);

    // Full ripple wrap-around.
    run_op(24'h999999, 24'h000001, 1'b0);
    check("t2_result", 32'(bus.result), 32'h000000);
    check("t2_cout",   32'(bus.cout),   32'd1);

    // Carry-in paths.
    run_op(24'h000000, 24'h000000, 1'b1);
    check("t3a_result", 32'(bus.result), 32'h000001);
    check("t3a_cout",   32'(bus.cout),   32'd0);
    run_op(24'h123456, 24'h876543, 1'b1);
    check("t3b_result", 32'(bus.result), 32'h000000);
    check("t3b_cout",   32'(bus.cout),   32'd1);

    // start re-pulsed during RUN is ignored.
    @(negedge clk);
    bus.op_a  = 24'h000123;
    bus.op_b  = 24'h000456;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    done_cnt  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 2) begin
        bus.start = 1'b1;
        bus.op_a  = 24'h111111;
        bus.op_b  = 24'h222222;
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) done_cnt++;
    end
    check("t4_done_count", 32'(done_cnt),   32'd1);
    check("t4_result",     32'(bus.result), 32'h000579);

    // start held high: back-to-back operations every NDIG+2 cycles.
    @(negedge clk);
    bus.op_a    = 24'h000001;
    bus.op_b    = 24'h000001;
    bus.start   = 1'b1;
    first_done  = 0;
    second_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first_done == 0) first_done = i;
        else if (second_done == 0) second_done = i;
      end
    end
    bus.start = 1'b0;
    check("t4_held_first", 32'(first_done), 32'd7);
    check("t4_held_gap",   32'(second_done - first_done), 32'd8);
    repeat (10) @(negedge clk);
    check("t4_held_result", 32'(bus.result), 32'h000002);

    // Invalid digit: computation proceeds, err flags it.
    run_op(24'h00000A, 24'h000001, 1'b0);
    check("t5_err",    32'(bus.err),    32'd1);
    check("t5_result", 32'(bus.result), 32'h000011);
    check("t5_cout",   32'(bus.cout),   32'd0);
    run_op(24'h000002, 24'h000003, 1'b0);
    check("t5_err_clr", 32'(bus.err),    32'd0);
    check("t5_result2", 32'(bus.result), 32'h000005);

    // Asynchronous reset at RUN cycle 3.
    @(negedge clk);
    bus.op_a  = 24'h111111;
    bus.op_b  = 24'h111111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_partial", 32'(bus.result), 32'h000022);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy",   32'(bus.busy),   32'd0);
    check("t6_done",   32'(bus.done),   32'd0);
    check("t6_result", 32'(bus.result), 32'd0);
    check("t6_cout",   32'(bus.cout),   32'd0);
    check("t6_err",    32'(bus.err),    32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("t6_no_done", 32'(done_cnt), 32'd0);
    run_op(24'h058959, 24'h001002, 1'b0);
    check("t6_after_done_at", 32'(done_at),    32'd7);
    check("t6_after_result",  32'(bus.result), 32'h059961);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
